ysyx_24080014_rf_csr: RTL
=========================

# ysyx_24080014_rf_csr

Parametrised integer register file and machine-mode CSR unit for the NPC single-issue core, sitting between decode/execute and writeback. It provides two GPR read ports and one commit write port, and stalls the commit of loads and stores until the memory side signals completion. It implements `mstatus`/`mtvec`/`mepc`/`mcause` with correct MIE/MPIE stacking on `ecall`/`mret`, and adds a free-running 64-bit `mcycle` counter. `XLEN` and GPR count (RV32E or RV32I) are parameters.

## Interface
Parameters:
- `XLEN`, 32, data width of GPRs and CSRs.
- `NR_GPR`, 16, number of GPRs; legal values 16 (RV32E) or 32 (RV32I).
- `MTVEC_RESET`, 0, reset value of `mtvec`.
- `MSTATUS_RESET`, `32'h1800`, reset value of `mstatus` (MPP = M).

Ports (one clock; reset is synchronous and active-high):
- `clk` input 1: clock.
- `rst` input 1: synchronous, active-high reset.
- `rs1_addr`, `rs2_addr` input 5 each: GPR read indices.
- `rs1_data`, `rs2_data` output XLEN each: combinational GPR read data.
- `csr_raddr` input 12: CSR read address.
- `csr_rdata` output XLEN: combinational CSR read data.
- `in_valid` input 1: a decoded instruction is presented for commit.
- `in_ready` output 1: commit accepted this cycle.
- `is_mem` input 1: the instruction is a load or store and must wait for `mem_ready`.
- `mem_ready` input 1: the memory access has completed.
- `rf_we` input 1: write `rd_data` to `rd`.
- `rd` input 5: destination register index.
- `rd_data` input XLEN: writeback value.
- `csr_op` input 2: 0 NONE, 1 WRITE, 2 ECALL, 3 MRET.
- `csr_waddr` input 12: CSR write address, used for WRITE.
- `csr_wdata` input XLEN: CSR write data.
- `pc` input XLEN: PC of the presented instruction.
- `next_pc` output XLEN: `mtvec` on ECALL, `mepc` on MRET, otherwise `pc+4`.
- `commit` output 1: equals `in_valid & in_ready`; one pulse per retired instruction.

## Operation
- FSM states are IDLE and WAIT_MEM; reset puts the FSM in IDLE.
- In IDLE, `in_ready = in_valid & (!is_mem | mem_ready)`.
- IDLE goes to WAIT_MEM when `in_valid & is_mem & !mem_ready`.
- In WAIT_MEM, `in_ready = mem_ready`; the FSM returns to IDLE on `mem_ready`.
- `in_valid` dropping while in WAIT_MEM returns the FSM to IDLE with no commit.
- All architectural updates happen only on a `commit` edge.
- GPR write occurs when `rf_we & rd != 0 & rd < NR_GPR`. Writes with `rd >= NR_GPR` are dropped silently.
- `x0` always reads 0.
- A read index `>= NR_GPR` returns 0.
- CSR WRITE updates `mstatus` (0x300), `mtvec` (0x305), `mepc` (0x341), `mcause` (0x342), `mcycle` (0xB00) or `mcycleh` (0xB80).
- Writes to other CSR addresses are ignored; reads of unimplemented CSRs return 0.
- ECALL, all in one edge:
  - `mepc` ← `pc`.
  - `mcause` ← 11.
  - `mstatus.MPIE` ← `mstatus.MIE`; `mstatus.MIE` ← 0.
  - `csr_waddr` is ignored.
- MRET: `mstatus.MIE` ← `MPIE`; `MPIE` ← 1.
- The GPR write and the CSR op of the same instruction both take effect on the same edge (csrrw semantics).
- `mcycle`:
  - 64-bit counter; increments every cycle, not only on commit.
  - Wraps from `2^64-1` to 0.
  - A committed write to either half loads that half with `csr_wdata` (other half unchanged); there is no increment that cycle, and counting resumes next cycle.
- Reset values:
  - All GPRs 0.
  - `mepc` 0, `mcause` 0, `mcycle` 0.
  - `mtvec` = `MTVEC_RESET`; `mstatus` = `MSTATUS_RESET`.
  - Outputs: `in_ready` 0, `commit` 0.

## Timing
- Reads are zero latency (combinational from the current array state).
- Writes are visible on read ports the cycle after `commit`, unless bypass is compiled in.
- Store/load commit latency is exactly the number of cycles until `mem_ready` is high. If `mem_ready` is already high in the first cycle, the commit happens that cycle.
- `rst` asserted in WAIT_MEM: the FSM returns to IDLE at that edge and nothing is committed.
- `rst` has priority over a simultaneous commit.
- `next_pc` is combinational from `csr_op`, `pc`, `mtvec` and `mepc`; it uses pre-update values on the commit cycle.

## Configuration
- `YSYX_24080014_RF_BYPASS_EN`:
  - Defined: a GPR read whose index matches a write committing in the same cycle (same `rd`, nonzero, in range) returns `rd_data` combinationally.
  - Undefined: the read returns the old array value.
- The CSR read port is never bypassed.

## Structure
- Package `ysyx_24080014_rf_pkg` holds:
  - CSR address constants.
  - `csr_op_e` (NONE/WRITE/ECALL/MRET).
  - `rf_state_e` (IDLE/WAIT_MEM).
  - `MCAUSE_ECALL_M = 11`.
  - `MSTATUS_MIE_BIT = 3`, `MSTATUS_MPIE_BIT = 7`.
- Sub-module `ysyx_24080014_csr_file` contains the CSRs, `mcycle` and `next_pc` logic. The top level contains the GPR array, FSM and bypass.

## Test plan
- Reset, then `rf_we`, `rd=5`, `rd_data=0xDEADBEEF`, `in_valid`, `is_mem=0` → `commit` is high that cycle; `rs1_addr=5` reads `0xDEADBEEF` the next cycle; a write to `rd=0` leaves `x0` reading 0.
- Load with `mem_ready` low for 3 cycles then high → `in_ready`/`commit` stay 0 for 3 cycles and pulse on cycle 4; `rd` updates only after that edge.
- `mstatus=0x1808`, `pc=0x80000010`, ECALL → `next_pc=mtvec`; then `mepc=0x80000010`, `mcause=11`, `mstatus=0x1880`. A following MRET → `next_pc=0x80000010`, `mstatus=0x1888`.
- `NR_GPR=16`, write `rd=20` → no GPR changes; read `rs2_addr=20` → 0.
- Write `mcycle=0xFFFFFFFF`, `mcycleh=0xFFFFFFFF` → after 1 idle cycle both read 0.
- With `YSYX_24080014_RF_BYPASS_EN`, a same-cycle write/read of `x7=0x1234` → `rs1_data=0x1234` in the commit cycle. Without the macro, the old value is returned.

Source files
------------

// File: rtl/ysyx_24080014_rf_pkg.sv
// Shared constants and types for the NPC register file / CSR unit.
// Bypass option: YSYX_24080014_RF_BYPASS_EN.
package ysyx_24080014_rf_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MCYCLE  = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH = 12'hB80;

  typedef enum logic [1:0] {
    CSR_NONE  = 2'd0,
    CSR_WRITE = 2'd1,
    CSR_ECALL = 2'd2,
    CSR_MRET  = 2'd3
  } csr_op_e;

  typedef enum logic {
    RF_IDLE     = 1'b0,
    RF_WAIT_MEM = 1'b1
  } rf_state_e;

  localparam int MCAUSE_ECALL_M   = 11;
  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;

endpackage

// File: rtl/ysyx_24080014_csr_file.sv
// Machine-mode CSRs, 64-bit mcycle and next_pc selection.
// Part of the rf_csr unit (bypass option YSYX_24080014_RF_BYPASS_EN).
module ysyx_24080014_csr_file
  import ysyx_24080014_rf_pkg::*;
#(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0,
  parameter logic [XLEN-1:0] MSTATUS_RESET = 'h1800
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            commit_i,
  input  logic [1:0]      csr_op_i,
  input  logic [11:0]     csr_waddr_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [11:0]     csr_raddr_i,
  output logic [XLEN-1:0] csr_rdata_o,
  output logic [XLEN-1:0] next_pc_o
);

  logic [XLEN-1:0] mstatus_q;
  logic [XLEN-1:0] mtvec_q;
  logic [XLEN-1:0] mepc_q;
  logic [XLEN-1:0] mcause_q;
  logic [63:0]     mcycle_q;
  logic [63:0]     mcycle_d;
  csr_op_e         op;
  logic            wr;

  assign op = csr_op_e'(csr_op_i);
  assign wr = commit_i && (op == CSR_WRITE);

  // A committed write to either half replaces that cycle's increment.
  always_comb begin
    mcycle_d = mcycle_q + 64'd1;
    if (wr && csr_waddr_i == CSR_MCYCLE)
      mcycle_d = {mcycle_q[63:32], csr_wdata_i[31:0]};
    else if (wr && csr_waddr_i == CSR_MCYCLEH)
      mcycle_d = {csr_wdata_i[31:0], mcycle_q[31:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_q <= MSTATUS_RESET;
      mtvec_q   <= MTVEC_RESET;
      mepc_q    <= '0;
      mcause_q  <= '0;
      mcycle_q  <= '0;
    end else begin
      mcycle_q <= mcycle_d;
      if (commit_i) begin
        unique case (op)
          CSR_WRITE: begin
            case (csr_waddr_i)
              CSR_MSTATUS: mstatus_q <= csr_wdata_i;
              CSR_MTVEC:   mtvec_q   <= csr_wdata_i;
              CSR_MEPC:    mepc_q    <= csr_wdata_i;
              CSR_MCAUSE:  mcause_q  <= csr_wdata_i;
              default: ;
            endcase
          end
          CSR_ECALL: begin
            mepc_q   <= pc_i;
            mcause_q <= XLEN'(MCAUSE_ECALL_M);
            mstatus_q[MSTATUS_MPIE_BIT] <= mstatus_q[MSTATUS_MIE_BIT];
            mstatus_q[MSTATUS_MIE_BIT]  <= 1'b0;
          end
          CSR_MRET: begin
            mstatus_q[MSTATUS_MIE_BIT]  <= mstatus_q[MSTATUS_MPIE_BIT];
            mstatus_q[MSTATUS_MPIE_BIT] <= 1'b1;
          end
          CSR_NONE: ;
        endcase
      end
    end
  end

  always_comb begin
    csr_rdata_o = '0;
    case (csr_raddr_i)
      CSR_MSTATUS: csr_rdata_o = mstatus_q;
      CSR_MTVEC:   csr_rdata_o = mtvec_q;
      CSR_MEPC:    csr_rdata_o = mepc_q;
      CSR_MCAUSE:  csr_rdata_o = mcause_q;
      CSR_MCYCLE:  csr_rdata_o = XLEN'(mcycle_q[31:0]);
      CSR_MCYCLEH: csr_rdata_o = XLEN'(mcycle_q[63:32]);
      default: ;
    endcase
  end

  always_comb begin
    unique case (op)
      CSR_ECALL: next_pc_o = mtvec_q;
      CSR_MRET:  next_pc_o = mepc_q;
      default:   next_pc_o = pc_i + XLEN'(4);
    endcase
  end

endmodule

// File: rtl/ysyx_24080014_rf_csr.sv
// GPR file, memory-wait commit FSM and CSR unit for the NPC core.
// Define YSYX_24080014_RF_BYPASS_EN to forward same-cycle writes to reads.
module ysyx_24080014_rf_csr
  import ysyx_24080014_rf_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NR_GPR = 16,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0,
  parameter logic [XLEN-1:0] MSTATUS_RESET = 'h1800
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic [11:0]     csr_raddr,
  output logic [XLEN-1:0] csr_rdata,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            is_mem,
  input  logic            mem_ready,
  input  logic            rf_we,
  input  logic [4:0]      rd,
  input  logic [XLEN-1:0] rd_data,
  input  logic [1:0]      csr_op,
  input  logic [11:0]     csr_waddr,
  input  logic [XLEN-1:0] csr_wdata,
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] next_pc,
  output logic            commit
);

  localparam int IDX_W = $clog2(NR_GPR);

  rf_state_e       state_q;
  rf_state_e       state_d;
  logic [XLEN-1:0] gpr_q [NR_GPR];
  logic            gpr_we;

  always_comb begin
    in_ready = 1'b0;
    state_d  = state_q;
    unique case (state_q)
      RF_IDLE: begin
        in_ready = in_valid & (~is_mem | mem_ready);
        if (in_valid & is_mem & ~mem_ready)
          state_d = RF_WAIT_MEM;
      end
      RF_WAIT_MEM: begin
        in_ready = mem_ready;
        if (mem_ready | ~in_valid)
          state_d = RF_IDLE;
      end
      default: state_d = RF_IDLE;
    endcase
    // Reset wins over any commit in the same cycle.
    if (rst)
      in_ready = 1'b0;
  end

  assign commit = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst)
      state_q <= RF_IDLE;
    else
      state_q <= state_d;
  end

  assign gpr_we = commit & rf_we & (rd != 5'd0) & (32'(rd) < NR_GPR);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NR_GPR; i++)
        gpr_q[i] <= '0;
    end else if (gpr_we) begin
      gpr_q[rd[IDX_W-1:0]] <= rd_data;
    end
  end

  always_comb begin
    rs1_data = '0;
    if (rs1_addr != 5'd0 && 32'(rs1_addr) < NR_GPR)
      rs1_data = gpr_q[rs1_addr[IDX_W-1:0]];
`ifdef YSYX_24080014_RF_BYPASS_EN
    if (gpr_we && rs1_addr == rd)
      rs1_data = rd_data;
`endif
  end

  always_comb begin
    rs2_data = '0;
    if (rs2_addr != 5'd0 && 32'(rs2_addr) < NR_GPR)
      rs2_data = gpr_q[rs2_addr[IDX_W-1:0]];
`ifdef YSYX_24080014_RF_BYPASS_EN
    if (gpr_we && rs2_addr == rd)
      rs2_data = rd_data;
`endif
  end

  ysyx_24080014_csr_file #(
    .XLEN          (XLEN),
    .MTVEC_RESET   (MTVEC_RESET),
    .MSTATUS_RESET (MSTATUS_RESET)
  ) u_csr (
    .clk         (clk),
    .rst         (rst),
    .commit_i    (commit),
    .csr_op_i    (csr_op),
    .csr_waddr_i (csr_waddr),
    .csr_wdata_i (csr_wdata),
    .pc_i        (pc),
    .csr_raddr_i (csr_raddr),
    .csr_rdata_o (csr_rdata),
    .next_pc_o   (next_pc)
  );

endmodule
